// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file sequencer: default bus widths,
// operation codes and FSM state encodings.
package regfile_pkg;

  localparam int unsigned DW_DEF = 8;
  localparam int unsigned AW_DEF = 3;

  typedef logic [2:0] op_t;

  localparam op_t OP_ADD  = 3'd0;
  localparam op_t OP_SUB  = 3'd1;
  localparam op_t OP_AND  = 3'd2;
  localparam op_t OP_OR   = 3'd3;
  localparam op_t OP_XOR  = 3'd4;
  localparam op_t OP_ADDI = 3'd5;
  localparam op_t OP_MOVI = 3'd6;
  localparam op_t OP_NOP  = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } state_e;

endpackage

// File: rtl/rf_alu.sv
// Combinational ALU for the register-file sequencer.
// Ports:
//   a_i, b_i     operands captured from the register file read buses
//   imm_i        immediate operand
//   op_i         operation code
//   res_o        DW-bit wrap-around result
//   carry_o      carry (ADD/ADDI) or borrow (SUB) out of the DW-bit result
//   carry_we_o   high when the op defines a new carry value
module rf_alu
  import regfile_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
) (
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  logic [DW-1:0] imm_i,
  input  op_t           op_i,
  output logic [DW-1:0] res_o,
  output logic          carry_o,
  output logic          carry_we_o
);

  // One extra bit so that bit DW is the carry, or the borrow for SUB.
  logic [DW:0] sum;

  always_comb begin
    sum        = '0;
    carry_we_o = 1'b0;
    case (op_i)
      OP_ADD: begin
        sum        = {1'b0, a_i} + {1'b0, b_i};
        carry_we_o = 1'b1;
      end
      OP_SUB: begin
        sum        = {1'b0, a_i} - {1'b0, b_i};
        carry_we_o = 1'b1;
      end
      OP_AND:  sum = {1'b0, a_i & b_i};
      OP_OR:   sum = {1'b0, a_i | b_i};
      OP_XOR:  sum = {1'b0, a_i ^ b_i};
      OP_ADDI: begin
        sum        = {1'b0, a_i} + {1'b0, imm_i};
        carry_we_o = 1'b1;
      end
      OP_MOVI: sum = {1'b0, imm_i};
      default: sum = '0;
    endcase
    res_o   = sum[DW-1:0];
    carry_o = sum[DW];
  end

endmodule

// File: rtl/regfile_sequencer.sv
// Initiator-side master for an 8x8 register file. Accepts one command over
// valid/ready, reads two registers, runs the ALU, writes the result back.
// Ports:
//   Clk, Rst           clock, synchronous active-high reset
//   cmd_*              command handshake and fields (sampled at handshake only)
//   RX, RY, busX, busY register file read ports
//   WEN, RW, busW      register file write port
//   done               one-cycle pulse when a command retires
//   result, carry      last computed result and carry/borrow flag
module regfile_sequencer
  import regfile_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned AW = AW_DEF
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [AW-1:0] cmd_rd,
  input  logic [AW-1:0] cmd_rs,
  input  logic [AW-1:0] cmd_rt,
  input  logic [DW-1:0] cmd_imm,
  output logic [AW-1:0] RX,
  output logic [AW-1:0] RY,
  input  logic [DW-1:0] busX,
  input  logic [DW-1:0] busY,
  output logic          WEN,
  output logic [AW-1:0] RW,
  output logic [DW-1:0] busW,
  output logic          done,
  output logic [DW-1:0] result,
  output logic          carry
);

  state_e        state_q, state_d;
  op_t           op_q, op_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [DW-1:0] imm_q, imm_d;
  logic [DW-1:0] a_q, a_d, b_q, b_d;
  logic [AW-1:0] rx_q, rx_d, ry_q, ry_d, rw_q, rw_d;
  logic [DW-1:0] busw_q, busw_d, result_q, result_d;
  logic          wen_q, wen_d, done_q, done_d, carry_q, carry_d;

  logic [DW-1:0] alu_res;
  logic          alu_carry, alu_carry_we;

  rf_alu #(
    .DW (DW)
  ) u_alu (
    .a_i        (a_q),
    .b_i        (b_q),
    .imm_i      (imm_q),
    .op_i       (op_q),
    .res_o      (alu_res),
    .carry_o    (alu_carry),
    .carry_we_o (alu_carry_we)
  );

  assign cmd_ready = (state_q == S_IDLE) && !Rst;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    imm_d    = imm_q;
    a_d      = a_q;
    b_d      = b_q;
    rx_d     = rx_q;
    ry_d     = ry_q;
    rw_d     = rw_q;
    busw_d   = busw_q;
    result_d = result_q;
    carry_d  = carry_q;
    wen_d    = 1'b0;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_d    = cmd_op;
          rd_d    = cmd_rd;
          imm_d   = cmd_imm;
          rx_d    = cmd_rs;
          ry_d    = cmd_rt;
          state_d = S_READ;
        end
      end
      S_READ: begin
        a_d     = busX;
        b_d     = busY;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        // NOP retires without touching result/carry; its busW mirrors the held result.
        if (op_q != OP_NOP) begin
          result_d = alu_res;
          busw_d   = alu_res;
          if (alu_carry_we) begin
            carry_d = alu_carry;
          end
        end else begin
          busw_d = result_q;
        end
        wen_d   = (op_q != OP_NOP) && (rd_q != '0);
        rw_d    = rd_q;
        done_d  = 1'b1;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= S_IDLE;
      op_q     <= OP_ADD;
      rd_q     <= '0;
      imm_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rx_q     <= '0;
      ry_q     <= '0;
      rw_q     <= '0;
      busw_q   <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      wen_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      imm_q    <= imm_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rx_q     <= rx_d;
      ry_q     <= ry_d;
      rw_q     <= rw_d;
      busw_q   <= busw_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      wen_q    <= wen_d;
      done_q   <= done_d;
    end
  end

  assign RX     = rx_q;
  assign RY     = ry_q;
  assign RW     = rw_q;
  assign busW   = busw_q;
  assign WEN    = wen_q;
  assign done   = done_q;
  assign result = result_q;
  assign carry  = carry_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer with a behavioural 8x8 register file.
module tb_regfile_sequencer;

  logic       Clk, Rst;
  logic       cmd_valid, cmd_ready;
  logic [2:0] cmd_op;
  logic [2:0] cmd_rd, cmd_rs, cmd_rt;
  logic [7:0] cmd_imm;
  logic [2:0] RX, RY, RW;
  logic [7:0] busX, busY, busW;
  logic       WEN, done, carry;
  logic [7:0] result;

  int checks   = 0;
  int failures = 0;
  int wen_count  = 0;
  int done_count = 0;
  logic rf_load;
  logic [7:0] rf [8];

  regfile_sequencer #(
    .DW (8),
    .AW (3)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_rd    (cmd_rd),
    .cmd_rs    (cmd_rs),
    .cmd_rt    (cmd_rt),
    .cmd_imm   (cmd_imm),
    .RX        (RX),
    .RY        (RY),
    .busX      (busX),
    .busY      (busY),
    .WEN       (WEN),
    .RW        (RW),
    .busW      (busW),
    .done      (done),
    .result    (result),
    .carry     (carry)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Register file: r0 reads zero, write on rising edge.
  assign busX = (RX == 3'd0) ? 8'h00 : rf[RX];
  assign busY = (RY == 3'd0) ? 8'h00 : rf[RY];

  always @(posedge Clk) begin
    if (rf_load) begin
      for (int i = 0; i < 8; i++) rf[i] <= 8'hA0 + 8'(i);
    end else if (WEN && RW != 3'd0) begin
      rf[RW] <= busW;
    end
    if (WEN)  wen_count  <= wen_count + 1;
    if (done) done_count <= done_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one command and follow it to retirement. When hold is set the
  // source keeps cmd_valid high with scrambled fields while the DUT is busy.
  task automatic do_cmd(input string tag, input logic [2:0] op, input logic [2:0] rd,
                        input logic [2:0] rs, input logic [2:0] rt, input logic [7:0] imm,
                        input logic exp_wen, input logic hold);
    int   lat;
    logic got, busy_ready, wen_seen;
    int   d0;
    d0 = done_count;
    @(negedge Clk);
    cmd_valid = 1'b1;
    cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_rt = rt; cmd_imm = imm;
    check({tag, ".ready"}, 32'(cmd_ready), 32'd1);
    @(posedge Clk);
    #1;
    if (hold) begin
      cmd_op = ~op; cmd_rd = ~rd; cmd_rs = ~rs; cmd_rt = ~rt; cmd_imm = ~imm;
    end else begin
      cmd_valid = 1'b0;
    end
    lat = 0; got = 1'b0; busy_ready = 1'b0; wen_seen = 1'b0;
    while (!got && lat < 8) begin
      @(negedge Clk);
      lat++;
      if (lat == 1) check({tag, ".rxry"}, 32'({RX, RY}), 32'({rs, rt}));
      if (cmd_ready) busy_ready = 1'b1;
      if (WEN) wen_seen = 1'b1;
      if (done) got = 1'b1;
    end
    check({tag, ".latency"}, 32'(lat), 32'd3);
    check({tag, ".busy_ready"}, 32'(busy_ready), 32'd0);
    check({tag, ".wen"}, 32'(wen_seen), 32'(exp_wen));
    if (exp_wen) check({tag, ".rw"}, 32'(RW), 32'(rd));
    @(posedge Clk);
    #1;
    cmd_valid = 1'b0;
    check({tag, ".done_once"}, 32'(done_count - d0), 32'd1);
  endtask

  int w0, d0;

  initial begin
    Rst = 1'b1; rf_load = 1'b1;
    cmd_valid = 1'b1; cmd_op = 3'd6; cmd_rd = 3'd1; cmd_rs = 3'd2; cmd_rt = 3'd3;
    cmd_imm = 8'h11;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("rst.ready", 32'(cmd_ready), 32'd0);
    check("rst.outs", 32'({WEN, done, carry, result, RX, RY, RW, busW}), 32'd0);
    rf_load = 1'b0; Rst = 1'b0; cmd_valid = 1'b0;
    #1;
    check("rst.ready_after", 32'(cmd_ready), 32'd1);
    check("rst.no_done", 32'(done_count), 32'd0);

    do_cmd("movi1", 3'd6, 3'd1, 3'd0, 3'd0, 8'h7F, 1'b1, 1'b0);
    check("movi1.res", 32'({carry, result}), 32'h07F);
    do_cmd("movi2", 3'd6, 3'd2, 3'd0, 3'd0, 8'h81, 1'b1, 1'b0);
    check("movi2.rf", 32'(rf[2]), 32'h81);
    do_cmd("add3", 3'd0, 3'd3, 3'd1, 3'd2, 8'h00, 1'b1, 1'b0);
    check("add3.res", 32'({carry, result}), 32'h100);
    check("add3.rf", 32'(rf[3]), 32'h00);
    do_cmd("sub4", 3'd1, 3'd4, 3'd1, 3'd2, 8'h00, 1'b1, 1'b0);
    check("sub4.res", 32'({carry, result}), 32'h1FE);
    check("sub4.rf", 32'(rf[4]), 32'hFE);
    do_cmd("sub5", 3'd1, 3'd5, 3'd2, 3'd1, 8'h00, 1'b1, 1'b0);
    check("sub5.res", 32'({carry, result}), 32'h002);
    check("sub5.rf", 32'(rf[5]), 32'h02);

    do_cmd("movi0", 3'd6, 3'd0, 3'd0, 3'd0, 8'h55, 1'b0, 1'b0);
    check("movi0.res", 32'({carry, result}), 32'h055);
    do_cmd("add6", 3'd0, 3'd6, 3'd0, 3'd0, 8'h00, 1'b1, 1'b0);
    check("add6.rf", 32'(rf[6]), 32'h00);

    do_cmd("addi_a", 3'd5, 3'd1, 3'd1, 3'd0, 8'h01, 1'b1, 1'b0);
    do_cmd("addi_b", 3'd5, 3'd1, 3'd1, 3'd0, 8'h01, 1'b1, 1'b0);
    do_cmd("addi_c", 3'd5, 3'd1, 3'd1, 3'd0, 8'h01, 1'b1, 1'b0);
    check("addi.rf", 32'(rf[1]), 32'h82);
    check("addi.res", 32'({carry, result}), 32'h082);

    // Abort XOR r7 during EXEC.
    w0 = wen_count; d0 = done_count;
    @(negedge Clk);
    cmd_valid = 1'b1; cmd_op = 3'd4; cmd_rd = 3'd7; cmd_rs = 3'd1; cmd_rt = 3'd2;
    cmd_imm = 8'h00;
    @(posedge Clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    check("abort.outs", 32'({WEN, done, carry, result, RX, RY, RW, busW}), 32'd0);
    check("abort.ready_in_rst", 32'(cmd_ready), 32'd0);
    Rst = 1'b0;
    #1;
    check("abort.ready", 32'(cmd_ready), 32'd1);
    repeat (3) @(negedge Clk);
    check("abort.counts", 32'({16'(wen_count - w0), 16'(done_count - d0)}), 32'd0);
    check("abort.rf7", 32'(rf[7]), 32'hA7);

    // Held valid with scrambled fields while busy: r1 = 0x82 + 0x81.
    do_cmd("hold_add", 3'd0, 3'd1, 3'd1, 3'd2, 8'h00, 1'b1, 1'b1);
    check("hold_add.res", 32'({carry, result}), 32'h103);
    check("hold_add.rf", 32'(rf[1]), 32'h03);
    w0 = wen_count;
    do_cmd("nop", 3'd7, 3'd5, 3'd1, 3'd2, 8'hEE, 1'b0, 1'b0);
    check("nop.res", 32'({carry, result}), 32'h103);
    check("nop.rf5", 32'(rf[5]), 32'h02);
    check("nop.wen_count", 32'(wen_count - w0), 32'd0);

    repeat (2) @(negedge Clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
